// File: rtl/swipt_pkg.sv
// Shared types, frequency limits and helpers for the SWIPT carrier generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package swipt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        UPDATE,
        DRAIN
    } state_t;

    localparam logic [31:0] F_DEFAULT = 32'd40000;
    localparam logic [31:0] F_MIN     = 32'd20000;
    localparam logic [31:0] F_MAX     = 32'd60000;

    // Tuning constant K = round(2^(acc_w+16) / clk_hz). The extra 16
    // fractional bits keep the Hz-to-increment conversion accurate.
    function automatic logic [63:0] calc_k(input int unsigned clk_hz,
                                           input int unsigned acc_w);
        logic [63:0] num;
        num = 64'd1 << (acc_w + 16);
        return (num + 64'(clk_hz / 2)) / 64'(clk_hz);
    endfunction

    function automatic logic [31:0] clamp_f(input logic [31:0] f);
        if (f < F_MIN) begin
            return F_MIN;
        end else if (f > F_MAX) begin
            return F_MAX;
        end
        return f;
    endfunction

endpackage

// File: rtl/swipt_carrier_gen_if.sv
// Frequency request channel: 32-bit Hz value with valid/ready.
// Latency: n/a (wires only).
// Backpressure: slave drops f_req_ready while a frequency change is in flight.
// Ports: f_req (Hz), f_req_valid, f_req_ready; transfer on valid && ready.
interface swipt_carrier_gen_if;
    logic [31:0] f_req;
    logic        f_req_valid;
    logic        f_req_ready;

    modport master (output f_req, output f_req_valid, input f_req_ready);
    modport slave  (input f_req, input f_req_valid, output f_req_ready);
endinterface

// File: rtl/swipt_phase_acc.sv
// Phase accumulator NCO core: Hz -> increment, accumulate, square-wave out.
// Latency: inc follows f_cur by 1 clk; link/cyc_stb registered from the add.
// Backpressure: none; run/clr are level controls from the FSM.
// Ports: clk, nrst, run (accumulate), clr (force acc to 0), f_cur (Hz),
//        wrap (combinational carry-out this cycle), link, cyc_stb.
module swipt_phase_acc import swipt_pkg::*; #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned ACC_W  = 32
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        run,
    input  logic        clr,
    input  logic [31:0] f_cur,
    output logic        wrap,
    output logic        link,
    output logic        cyc_stb
);

    localparam logic [63:0]    K      = calc_k(CLK_HZ, ACC_W);
    localparam int             K_W    = $clog2(K + 64'd1);
    localparam int             PROD_W = 32 + K_W;
    localparam logic [K_W-1:0] K_C    = K[K_W-1:0];

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  inc_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W:0]    sum;
    logic              link_q;
    logic              cyc_stb_q;
    logic              unused_prod;

    assign prod        = PROD_W'(f_cur) * PROD_W'(K_C);
    assign unused_prod = ^{prod[15:0], prod[PROD_W-1:ACC_W+16]};

    assign sum  = {1'b0, acc_q} + {1'b0, inc_q};
    assign wrap = run & sum[ACC_W];

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (run) begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    // link is taken from the next accumulator value so that its falling
    // edge and cyc_stb land on the same clock edge as the wrap.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inc_q     <= '0;
            acc_q     <= '0;
            link_q    <= 1'b0;
            cyc_stb_q <= 1'b0;
        end else begin
            inc_q     <= prod[ACC_W+15:16];
            acc_q     <= acc_d;
            link_q    <= acc_d[ACC_W-1];
            cyc_stb_q <= wrap;
        end
    end

    assign link    = link_q;
    assign cyc_stb = cyc_stb_q;

endmodule

// File: rtl/swipt_carrier_gen.sv
// SWIPT transmit carrier: NCO square wave with phase-continuous retuning.
// Latency: en -> link_alive 1 clk; request -> f_cur at next wrap (or slewed).
// Backpressure: f_req_ready low while an UPDATE is in progress.
// Ports: clk, nrst (async, active-low), en, req (slave request channel),
//        link, link_alive, f_cur (Hz), cyc_stb (pulse on link fall).
// Build option: SWIPT_CARRIER_SLEW_EN selects stepped slewing in UPDATE.
module swipt_carrier_gen import swipt_pkg::*; #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned ACC_W    = 32
`ifdef SWIPT_CARRIER_SLEW_EN
    ,
    parameter int unsigned STEP_HZ  = 1000,
    parameter int unsigned SLEW_DIV = 1000
`endif
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    swipt_carrier_gen_if.slave   req,
    output logic                 link,
    output logic                 link_alive,
    output logic [31:0]          f_cur,
    output logic                 cyc_stb
);

    state_t      state_q;
    logic [31:0] target_q;
    logic [31:0] f_cur_q;
    logic        link_alive_q;
    logic        f_req_ready_q;
    logic        accept;
    logic [31:0] f_req_c;
    logic        wrap;
    logic        acc_run;
    logic        acc_clr;

    assign accept  = req.f_req_valid & f_req_ready_q;
    assign f_req_c = clamp_f(req.f_req);

    assign acc_run = (state_q != IDLE);
    // Stop only on the wrap so the last high phase is never cut short.
    assign acc_clr = (state_q == DRAIN) & ~en & wrap;

`ifdef SWIPT_CARRIER_SLEW_EN
    localparam int CNT_W = $clog2(SLEW_DIV);

    logic [CNT_W-1:0] slew_cnt_q;
    logic [31:0]      slew_diff;
    logic [31:0]      slew_amt;

    assign slew_diff = (target_q > f_cur_q) ? (target_q - f_cur_q) : (f_cur_q - target_q);
    assign slew_amt  = (slew_diff > 32'(STEP_HZ)) ? 32'(STEP_HZ) : slew_diff;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            target_q      <= F_DEFAULT;
            f_cur_q       <= F_DEFAULT;
            link_alive_q  <= 1'b0;
            f_req_ready_q <= 1'b1;
`ifdef SWIPT_CARRIER_SLEW_EN
            slew_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        target_q <= f_req_c;
                        f_cur_q  <= f_req_c;
                    end
                    if (en) begin
                        state_q      <= RUN;
                        link_alive_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        target_q <= f_req_c;
                    end
                    if (!en) begin
                        state_q <= DRAIN;
                    end else if (accept && (f_req_c != f_cur_q)) begin
                        state_q       <= UPDATE;
                        f_req_ready_q <= 1'b0;
`ifdef SWIPT_CARRIER_SLEW_EN
                        slew_cnt_q    <= '0;
`endif
                    end
                end
                UPDATE: begin
                    if (!en) begin
                        state_q       <= DRAIN;
                        f_req_ready_q <= 1'b1;
                    end else if (f_cur_q == target_q) begin
                        state_q       <= RUN;
                        f_req_ready_q <= 1'b1;
`ifdef SWIPT_CARRIER_SLEW_EN
                    end else if (slew_cnt_q == CNT_W'(SLEW_DIV - 1)) begin
                        slew_cnt_q <= '0;
                        f_cur_q    <= (target_q > f_cur_q) ? (f_cur_q + slew_amt)
                                                           : (f_cur_q - slew_amt);
                    end else begin
                        slew_cnt_q <= slew_cnt_q + CNT_W'(1);
                    end
`else
                    end else if (wrap) begin
                        // Retune exactly at the period boundary: no runt pulse.
                        f_cur_q       <= target_q;
                        state_q       <= RUN;
                        f_req_ready_q <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (accept) begin
                        target_q <= f_req_c;
                    end
                    if (en) begin
                        if (accept && (f_req_c != f_cur_q)) begin
                            state_q       <= UPDATE;
                            f_req_ready_q <= 1'b0;
`ifdef SWIPT_CARRIER_SLEW_EN
                            slew_cnt_q    <= '0;
`endif
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (wrap) begin
                        state_q      <= IDLE;
                        link_alive_q <= 1'b0;
                        f_cur_q      <= accept ? f_req_c : target_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    swipt_phase_acc #(
        .CLK_HZ (CLK_HZ),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk     (clk),
        .nrst    (nrst),
        .run     (acc_run),
        .clr     (acc_clr),
        .f_cur   (f_cur_q),
        .wrap    (wrap),
        .link    (link),
        .cyc_stb (cyc_stb)
    );

    assign link_alive      = link_alive_q;
    assign f_cur           = f_cur_q;
    assign req.f_req_ready = f_req_ready_q;

endmodule
